// File: rtl/sched_acc_select.sv
// Request-side scheduler: looks a task type up in the scheduling table and grants a free accelerator.
// Optional round-robin start offsets per table entry are enabled with `define SCHED_ROUND_ROBIN_EN.
module sched_acc_select #(
  parameter int MAX_ACCS = 16,
  localparam int ACC_BITS = $clog2(MAX_ACCS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sched_table_ready,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [33:0]         req_task_type,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_found,
  output logic [ACC_BITS-1:0] rsp_acc_id,
  input  logic [MAX_ACCS-1:0] acc_avail,
  output logic [ACC_BITS-1:0] scheduleData_portB_addr,
  output logic                scheduleData_portB_en,
  input  logic [49:0]         scheduleData_portB_dout
);

  // Table word layout: TASK_TYPE[49:16], ACCID[15:8], COUNT[7:0]
  localparam int SCHED_DATA_TASK_TYPE_L = 16;
  localparam int SCHED_DATA_ACCID_L     = 8;
  localparam int SCHED_DATA_COUNT_L     = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_COMPARE = 3'd2,
    S_SELECT  = 3'd3,
    S_RESPOND = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_BITS-1:0] i_q, i_d;
  logic [33:0]         type_q, type_d;
  logic [ACC_BITS-1:0] accid_q, accid_d;
  logic [ACC_BITS-1:0] count_q, count_d;
  logic [ACC_BITS-1:0] k_q, k_d;
  logic                found_q, found_d;
  logic [ACC_BITS-1:0] acc_id_q, acc_id_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic                en_q, en_d;
  logic [ACC_BITS-1:0] addr_q, addr_d;

  logic [33:0]         dout_type_s;
  logic [ACC_BITS-1:0] dout_accid_s;
  logic [ACC_BITS-1:0] dout_count_s;
  logic [ACC_BITS-1:0] cand_s;
  logic [ACC_BITS-1:0] k_next_s;
  logic [ACC_BITS-1:0] start_s;
  logic                unused_dout_s;

`ifdef SCHED_ROUND_ROBIN_EN
  logic [ACC_BITS-1:0] ptr_q [MAX_ACCS];
  logic [ACC_BITS-1:0] ptr_d [MAX_ACCS];
`endif

  assign dout_type_s   = scheduleData_portB_dout[SCHED_DATA_TASK_TYPE_L +: 34];
  assign dout_accid_s  = scheduleData_portB_dout[SCHED_DATA_ACCID_L +: ACC_BITS];
  assign dout_count_s  = scheduleData_portB_dout[SCHED_DATA_COUNT_L +: ACC_BITS];
  assign unused_dout_s = ^{scheduleData_portB_dout[SCHED_DATA_TASK_TYPE_L-1:SCHED_DATA_ACCID_L+ACC_BITS],
                           scheduleData_portB_dout[SCHED_DATA_ACCID_L-1:SCHED_DATA_COUNT_L+ACC_BITS]};

  assign cand_s   = accid_q + k_q;
  assign k_next_s = (k_q == count_q) ? {ACC_BITS{1'b0}} : k_q + {{(ACC_BITS-1){1'b0}}, 1'b1};

`ifdef SCHED_ROUND_ROBIN_EN
  assign start_s = ptr_q[i_q];
`else
  assign start_s = {ACC_BITS{1'b0}};
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    type_d   = type_q;
    accid_d  = accid_q;
    count_d  = count_q;
    k_d      = k_q;
    found_d  = found_q;
    acc_id_d = acc_id_q;
`ifdef SCHED_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ready_q && req_valid) begin
          type_d   = req_task_type;
          i_d      = {ACC_BITS{1'b0}};
          found_d  = 1'b0;
          acc_id_d = {ACC_BITS{1'b0}};
          state_d  = S_READ;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (dout_type_s == 34'd0) begin
          found_d  = 1'b0;
          acc_id_d = {ACC_BITS{1'b0}};
          state_d  = S_RESPOND;
        end else if (dout_type_s == type_q) begin
          accid_d = dout_accid_s;
          count_d = dout_count_s;
          k_d     = start_s;
          state_d = S_SELECT;
        end else if (i_q == ACC_BITS'(MAX_ACCS - 1)) begin
          found_d  = 1'b0;
          acc_id_d = {ACC_BITS{1'b0}};
          state_d  = S_RESPOND;
        end else begin
          i_d     = i_q + {{(ACC_BITS-1){1'b0}}, 1'b1};
          state_d = S_READ;
        end
      end
      S_SELECT: begin
        // Without a free instance this keeps cycling through the candidates
        if (acc_avail[cand_s]) begin
          found_d  = 1'b1;
          acc_id_d = cand_s;
          state_d  = S_RESPOND;
        end else begin
          k_d      = k_next_s;
          state_d  = S_SELECT;
        end
      end
      S_RESPOND: begin
        if (rsp_ready) begin
`ifdef SCHED_ROUND_ROBIN_EN
          if (found_q) begin
            ptr_d[i_q] = k_next_s;
          end else begin
            ptr_d[i_q] = ptr_q[i_q];
          end
`endif
          state_d = S_IDLE;
        end else begin
          state_d = S_RESPOND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d = (state_d == S_RESPOND);
    ready_d = (state_d == S_IDLE) && sched_table_ready;
    en_d    = (state_d == S_READ);
    addr_d  = (state_d == S_READ) ? i_d : addr_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      i_q      <= {ACC_BITS{1'b0}};
      type_q   <= 34'd0;
      accid_q  <= {ACC_BITS{1'b0}};
      count_q  <= {ACC_BITS{1'b0}};
      k_q      <= {ACC_BITS{1'b0}};
      found_q  <= 1'b0;
      acc_id_q <= {ACC_BITS{1'b0}};
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      en_q     <= 1'b0;
      addr_q   <= {ACC_BITS{1'b0}};
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      type_q   <= type_d;
      accid_q  <= accid_d;
      count_q  <= count_d;
      k_q      <= k_d;
      found_q  <= found_d;
      acc_id_q <= acc_id_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
    end
  end

`ifdef SCHED_ROUND_ROBIN_EN
  // Per-entry round-robin start offsets
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < MAX_ACCS; n++) begin
        ptr_q[n] <= {ACC_BITS{1'b0}};
      end
    end else begin
      for (int n = 0; n < MAX_ACCS; n++) begin
        ptr_q[n] <= ptr_d[n];
      end
    end
  end
`endif

  assign req_ready               = ready_q;
  assign rsp_valid               = valid_q;
  assign rsp_found               = found_q;
  assign rsp_acc_id              = acc_id_q;
  assign scheduleData_portB_en   = en_q;
  assign scheduleData_portB_addr = addr_q;

endmodule

// File: tb/tb_sched_acc_select.sv
// Self-checking bench for sched_acc_select: directed scenarios plus randomized tables and requests
// checked against a table-search reference model.
module tb_sched_acc_select;

  localparam int MAX_ACCS = 16;
  localparam int ACC_BITS = 4;

  logic                clk = 1'b0;
  logic                rstn;
  logic                sched_table_ready;
  logic                req_valid;
  logic                req_ready;
  logic [33:0]         req_task_type;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_found;
  logic [ACC_BITS-1:0] rsp_acc_id;
  logic [MAX_ACCS-1:0] acc_avail;
  logic [ACC_BITS-1:0] portb_addr;
  logic                portb_en;
  logic [49:0]         portb_dout;

  logic [33:0] tt_tab  [MAX_ACCS];
  logic [3:0]  acc_tab [MAX_ACCS];
  logic [3:0]  cnt_tab [MAX_ACCS];
  logic [3:0]  model_ptr [MAX_ACCS];

  int tests_run    = 0;
  int tests_failed = 0;

  sched_acc_select #(.MAX_ACCS(MAX_ACCS)) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .sched_table_ready       (sched_table_ready),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_task_type           (req_task_type),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_found               (rsp_found),
    .rsp_acc_id              (rsp_acc_id),
    .acc_avail               (acc_avail),
    .scheduleData_portB_addr (portb_addr),
    .scheduleData_portB_en   (portb_en),
    .scheduleData_portB_dout (portb_dout)
  );

  always #5 clk = ~clk;

  // Scheduling table memory, one cycle read latency
  always @(posedge clk) begin
    if (portb_en) portb_dout <= {tt_tab[portb_addr], 4'd0, acc_tab[portb_addr], 4'd0, cnt_tab[portb_addr]};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the table, then scan instances from the start offset modulo (COUNT+1)
  task automatic model(input logic [33:0] tt, input logic [15:0] avail,
                       output bit found, output logic [3:0] id, output int lat,
                       output int ent, output logic [3:0] nptr);
    int start;
    found = 1'b0; id = 4'd0; lat = -1; ent = -1; nptr = 4'd0;
    for (int j = 0; j < MAX_ACCS; j++) begin
      if (tt_tab[j] == 34'd0) begin
        lat = 2 + 2 * j;
        break;
      end
      if (tt_tab[j] == tt) begin
        ent = j;
`ifdef SCHED_ROUND_ROBIN_EN
        start = int'(model_ptr[j]);
`else
        start = 0;
`endif
        for (int s = 0; s <= int'(cnt_tab[j]); s++) begin
          int off;
          off = (start + s) % (int'(cnt_tab[j]) + 1);
          if (avail[int'(acc_tab[j]) + off]) begin
            found = 1'b1;
            id    = 4'(int'(acc_tab[j]) + off);
            lat   = 3 + 2 * j + s;
            nptr  = (off == int'(cnt_tab[j])) ? 4'd0 : 4'(off + 1);
            break;
          end
        end
        break;
      end
      if (j == MAX_ACCS - 1) lat = 2 + 2 * j;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_before_req", req_ready, 1'b1);
  endtask

  task automatic accept(input logic [33:0] tt);
    req_valid = 1'b1;
    req_task_type = tt;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", rsp_valid, 1'b0);
    check("req_ready_after_hs", req_ready, 1'b1);
  endtask

  task automatic run_req(input logic [33:0] tt, input int hold);
    bit exp_found; logic [3:0] exp_id; int exp_lat, ent; logic [3:0] nptr;
    int n;
    model(tt, acc_avail, exp_found, exp_id, exp_lat, ent, nptr);
    wait_ready();
    accept(tt);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_valid_seen", rsp_valid, 1'b1);
    check("latency", 64'(n), 64'(exp_lat));
    check("rsp_found", rsp_found, exp_found);
    check("rsp_acc_id", rsp_acc_id, exp_id);
    check("req_ready_busy", req_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_found", rsp_found, exp_found);
      check("hold_acc_id", rsp_acc_id, exp_id);
    end
    finish_rsp();
    if (exp_found) model_ptr[ent] = nptr;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int j = 0; j < MAX_ACCS; j++) model_ptr[j] = 4'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_found"}, rsp_found, 1'b0);
    check({tag, "_rsp_acc_id"}, rsp_acc_id, 4'd0);
    check({tag, "_portb_en"}, portb_en, 1'b0);
    check({tag, "_portb_addr"}, portb_addr, 4'd0);
  endtask

  initial begin
    int n;
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_task_type = 34'd0;
    sched_table_ready = 1'b1; acc_avail = 16'h0000;
    for (int j = 0; j < MAX_ACCS; j++) begin
      tt_tab[j] = 34'd0; acc_tab[j] = 4'd0; cnt_tab[j] = 4'd0; model_ptr[j] = 4'd0;
    end
    tt_tab[0] = 34'h11; acc_tab[0] = 4'd0; cnt_tab[0] = 4'd1;
    tt_tab[1] = 34'h22; acc_tab[1] = 4'd2; cnt_tab[1] = 4'd2;

    #1 check_reset_outputs("reset");
    @(posedge clk); #1;
    check_reset_outputs("reset_clk");
    rstn = 1'b1;

    // Directed: match at entry 1, round-robin wrap, miss at end marker
    acc_avail = 16'hFFFF;
    run_req(34'h22, 0);
    run_req(34'h22, 5);
    run_req(34'h22, 0);
    run_req(34'h22, 1);
    run_req(34'h33, 2);

    // Directed: nothing free, one instance freed after 10 cycles
    acc_avail = 16'h0000;
    wait_ready();
    accept(34'h11);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("busy_no_rsp", rsp_valid, 1'b0);
      check("busy_req_ready", req_ready, 1'b0);
    end
    acc_avail = 16'h0002;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("busy_rsp_valid", rsp_valid, 1'b1);
    check("busy_found", rsp_found, 1'b1);
    check("busy_acc_id", rsp_acc_id, 4'd1);
    finish_rsp();
    model_ptr[0] = 4'd0;

    // Directed: advance entry 0 pointer, then reset during SELECT
    acc_avail = 16'hFFFF;
    run_req(34'h11, 0);
    acc_avail = 16'h0000;
    wait_ready();
    accept(34'h22);
    repeat (6) @(posedge clk);
    #3 rstn = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int j = 0; j < MAX_ACCS; j++) model_ptr[j] = 4'd0;
    acc_avail = 16'hFFFF;
    run_req(34'h11, 0);
    check("post_reset_ptr_id", model_ptr[0], 4'd1);

    // Randomized tables and requests
    for (int t = 0; t < 6; t++) begin
      int ntab;
      ntab = (t == 0) ? MAX_ACCS : int'($urandom_range(1, MAX_ACCS));
      for (int j = 0; j < MAX_ACCS; j++) begin
        if (j < ntab) begin
          cnt_tab[j] = 4'($urandom_range(0, 3));
          acc_tab[j] = 4'($urandom_range(0, 15 - int'(cnt_tab[j])));
          tt_tab[j]  = {29'($urandom), 5'(j + 1)};
        end else begin
          tt_tab[j] = 34'd0; acc_tab[j] = 4'd0; cnt_tab[j] = 4'd0;
        end
      end
      do_reset();
      for (int r = 0; r < 10; r++) begin
        logic [33:0] tt;
        int e;
        logic [15:0] av;
        e  = int'($urandom_range(0, ntab - 1));
        av = 16'($urandom);
        if ($urandom_range(0, 1) == 0) av = 16'h0001 << $urandom_range(0, 15);
        if ($urandom_range(0, 4) == 0) begin
          tt = {29'($urandom), 5'd31};
        end else begin
          bit any;
          tt = tt_tab[e];
          any = 1'b0;
          for (int o = 0; o <= int'(cnt_tab[e]); o++) any |= av[int'(acc_tab[e]) + o];
          if (!any) av[int'(acc_tab[e]) + int'($urandom_range(0, int'(cnt_tab[e])))] = 1'b1;
        end
        acc_avail = av;
        run_req(tt, int'($urandom_range(0, 2)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
